// File: rtl/bit_reverse_pkg.sv
// Shared definitions for the bit_reverse_stream block.
// Holds the permutation mode encodings used by the top level and by permute_core.
package bit_reverse_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_PASS           = 2'd0;
  localparam mode_t MODE_BITREV         = 2'd1;
  localparam mode_t MODE_BYTEREV        = 2'd2;
  localparam mode_t MODE_BITREV_IN_BYTE = 2'd3;

endpackage

// File: rtl/permute_core.sv
// Combinational word permutation.
// Ports:
//   data_in  - word to permute (WIDTH bits, WIDTH a multiple of 8)
//   mode     - permutation select (see bit_reverse_pkg)
//   data_out - permuted word
module permute_core
  import bit_reverse_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] data_in,
  input  mode_t            mode,
  output logic [WIDTH-1:0] data_out
);

  localparam int unsigned NBytes = WIDTH / 8;

  logic [WIDTH-1:0] rev_bits;
  logic [WIDTH-1:0] rev_bytes;
  logic [WIDTH-1:0] rev_in_byte;

  for (genvar i = 0; i < WIDTH; i++) begin : gen_rev_bits
    assign rev_bits[i] = data_in[WIDTH-1-i];
  end

  for (genvar j = 0; j < NBytes; j++) begin : gen_byte
    for (genvar b = 0; b < 8; b++) begin : gen_bit
      assign rev_bytes[8*(NBytes-1-j)+b] = data_in[8*j+b];
      assign rev_in_byte[8*j+b]          = data_in[8*j+7-b];
    end
  end

  always_comb begin
    data_out = data_in;
    case (mode)
      MODE_PASS:           data_out = data_in;
      MODE_BITREV:         data_out = rev_bits;
      MODE_BYTEREV:        data_out = rev_bytes;
      MODE_BITREV_IN_BYTE: data_out = rev_in_byte;
      default:             data_out = data_in;
    endcase
  end

endmodule

// File: rtl/bit_reverse_stream.sv
// Two-stage valid/ready pipeline that permutes each word according to the mode
// sampled with it. S1 holds the raw word and mode, S2 holds the permuted result.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   in_valid/in_ready    - input handshake; din and mode travel with in_valid
//   out_valid/out_ready  - output handshake; dout is the permuted word
//   word_cnt             - wrapping count of completed output handshakes
module bit_reverse_stream
  import bit_reverse_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] din,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] word_cnt
);

  if (WIDTH < 8 || (WIDTH % 8) != 0) begin : gen_bad_width
    $error("bit_reverse_stream: WIDTH must be a multiple of 8 and at least 8");
  end

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_data_q, s1_data_d;
  mode_t            s1_mode_q, s1_mode_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_data_q, s2_data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             s1_adv;
  logic             accept;
  logic             deliver;
  logic [WIDTH-1:0] perm_data;

  permute_core #(
    .WIDTH (WIDTH)
  ) u_permute_core (
    .data_in  (s1_data_q),
    .mode     (s1_mode_q),
    .data_out (perm_data)
  );

  always_comb begin
    s1_adv   = s1_valid_q && (!s2_valid_q || out_ready);
    // Gated by rst_n so upstream sees not-ready for the whole reset interval.
    in_ready = rst_n && (!s1_valid_q || s1_adv);
    accept   = in_valid && in_ready;
    deliver  = s2_valid_q && out_ready;
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_mode_d  = s1_mode_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_data_d  = din;
      s1_mode_d  = mode;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  // S2 data only changes on an advance, so dout stays put while idle or stalled.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    if (s1_adv) begin
      s2_valid_d = 1'b1;
      s2_data_d  = perm_data;
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (deliver) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_mode_q  <= MODE_PASS;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_mode_q  <= s1_mode_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign dout      = s2_data_q;
  assign word_cnt  = cnt_q;

endmodule

// File: tb/tb_bit_reverse_stream.sv
// Self-checking bench for bit_reverse_stream at WIDTH=16, CNT_W=4.
// The reference model is a queue of expected words, each tagged with the edge on
// which it was accepted; a word becomes visible one edge after acceptance.
module tb_bit_reverse_stream;

  logic        clk;
  logic        clk_en;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] din;
  logic [1:0]  mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] dout;
  logic [3:0]  word_cnt;

  bit_reverse_stream #(
    .WIDTH (16),
    .CNT_W (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (din),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .word_cnt  (word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = clk_en ? ~clk : clk;

  int n_checks = 0;
  int n_fails  = 0;

  logic [15:0] exp_q[$];
  int          acc_q[$];
  logic [15:0] out_cap[$];
  int          edge_n   = 0;
  int          hs_total = 0;
  int          cnt_m    = 0;
  bit          last_acc;
  bit          wrap_chk = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_perm(input logic [15:0] d, input logic [1:0] m);
    logic [15:0] r;
    r = d;
    case (m)
      2'd1: for (int i = 0; i < 16; i++) r[i] = d[15-i];
      2'd2: r = {d[7:0], d[15:8]};
      2'd3: for (int i = 0; i < 8; i++) begin
        r[i]   = d[7-i];
        r[8+i] = d[15-i];
      end
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic void model_clear();
    exp_q.delete();
    acc_q.delete();
    cnt_m = 0;
  endfunction

  // One clock: check outputs at the negedge, advance the model across the posedge.
  task automatic cycle();
    bit exp_rdy, exp_ov, acc, dlv;
    @(negedge clk);
    exp_rdy = (exp_q.size() < 2) || out_ready;
    exp_ov  = (exp_q.size() > 0) && (acc_q[0] < edge_n);
    check_eq("in_ready", in_ready, exp_rdy);
    check_eq("out_valid", out_valid, exp_ov);
    if (exp_ov) check_eq("dout", dout, exp_q[0]);
    check_eq("word_cnt", word_cnt, cnt_m);
    acc = in_valid && exp_rdy;
    dlv = exp_ov && out_ready;
    if (dlv) out_cap.push_back(dout);
    @(posedge clk);
    edge_n++;
    if (dlv) begin
      void'(exp_q.pop_front());
      void'(acc_q.pop_front());
      cnt_m = (cnt_m + 1) % 16;
      hs_total++;
    end
    if (acc) begin
      exp_q.push_back(ref_perm(din, mode));
      acc_q.push_back(edge_n);
    end
    last_acc = acc;
    #1;
    if (wrap_chk && dlv && hs_total >= 15) check_eq("wrap_cnt", word_cnt, hs_total % 16);
  endtask

  task automatic send(input logic [15:0] d, input logic [1:0] m);
    int tries;
    in_valid = 1'b1;
    din      = d;
    mode     = m;
    tries    = 0;
    do begin
      cycle();
      tries++;
    end while (!last_acc && tries < 20);
    if (!last_acc) check_eq("send_timeout", 32'(tries), 32'd0);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  logic [15:0] held;

  initial begin
    clk_en    = 1'b1;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    din       = '0;
    mode      = '0;
    out_ready = 1'b1;

    // Reset state.
    #2;
    check_eq("rst_in_ready", in_ready, 1'b0);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_dout", dout, 16'h0);
    check_eq("rst_word_cnt", word_cnt, 4'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check_eq("rel_in_ready", in_ready, 1'b1);

    // Throughput: 8 back-to-back words.
    for (int i = 0; i < 8; i++) send(16'($urandom), 2'($urandom));
    idle(2);
    check_eq("thru_word_cnt", word_cnt, 4'd8);

    // Mode sweep.
    out_cap.delete();
    send(16'h0001, 2'd0);
    send(16'h0001, 2'd1);
    send(16'h0001, 2'd2);
    send(16'h0001, 2'd3);
    send(16'h1234, 2'd2);
    idle(3);
    check_eq("sweep_n", out_cap.size(), 5);
    if (out_cap.size() == 5) begin
      check_eq("sweep_pass", out_cap[0], 16'h0001);
      check_eq("sweep_bitrev", out_cap[1], 16'h8000);
      check_eq("sweep_byterev", out_cap[2], 16'h0100);
      check_eq("sweep_bib", out_cap[3], 16'h0080);
      check_eq("sweep_1234", out_cap[4], 16'h3412);
    end

    // Mode alternating every word.
    out_cap.delete();
    for (int i = 0; i < 6; i++) send(16'h00F1, (i % 2 == 0) ? 2'd1 : 2'd2);
    idle(3);
    check_eq("alt_n", out_cap.size(), 6);
    for (int i = 0; i < out_cap.size(); i++)
      check_eq("alt_word", out_cap[i], (i % 2 == 0) ? 16'h8F00 : 16'hF100);

    // Backpressure: 3 words offered over 4 stalled cycles.
    out_cap.delete();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    din = 16'hA001; mode = 2'd0;
    cycle();
    din = 16'hB002; mode = 2'd0;
    cycle();
    held = dout;
    din = 16'hC003; mode = 2'd0;
    cycle();
    cycle();
    check_eq("bp_in_ready", in_ready, 1'b0);
    check_eq("bp_dout_held", dout, 16'hA001);
    check_eq("bp_out_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    idle(4);
    check_eq("bp_n", out_cap.size(), 3);
    if (out_cap.size() == 3) begin
      check_eq("bp_w0", out_cap[0], 16'hA001);
      check_eq("bp_w1", out_cap[1], 16'hB002);
      check_eq("bp_w2", out_cap[2], 16'hC003);
    end

    // Reset mid-stream with two words in flight and the clock stopped.
    out_ready = 1'b0;
    send(16'h1111, 2'd1);
    send(16'h2222, 2'd2);
    clk_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_out_valid", out_valid, 1'b0);
    check_eq("mid_rst_word_cnt", word_cnt, 4'd0);
    check_eq("mid_rst_in_ready", in_ready, 1'b0);
    #3;
    rst_n = 1'b1;
    #1;
    check_eq("mid_rel_in_ready", in_ready, 1'b1);
    model_clear();
    clk_en    = 1'b1;
    out_ready = 1'b1;
    out_cap.delete();
    idle(4);
    check_eq("no_stale", out_cap.size(), 0);

    // Counter wrap over 17 handshakes.
    hs_total = 0;
    wrap_chk = 1'b1;
    for (int i = 0; i < 17; i++) send(16'($urandom), 2'($urandom));
    idle(3);
    wrap_chk = 1'b0;
    check_eq("wrap_total", hs_total, 17);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom);
      din       = 16'($urandom);
      mode      = 2'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    out_ready = 1'b1;
    idle(4);
    check_eq("drain_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/bit_reverse_stream.md
BIT_REVERSE_STREAM -- requirements
Module: bit_reverse_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning data width in bits, legal values multiples of 8, at least 8.
REQ-002 SHALL have parameter CNT_W, default 8, meaning width of the output-word counter.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  din/mode are valid this cycle.
REQ-006 SHALL have port in_ready  output  1  block can accept a word this cycle.
REQ-007 SHALL have port din  input  WIDTH  input word.
REQ-008 SHALL have port mode  input  2  permutation select, sampled with din.
REQ-009 SHALL have port out_valid  output  1  dout is valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts dout.
REQ-011 SHALL have port dout  output  WIDTH  permuted word.
REQ-012 SHALL have port word_cnt  output  CNT_W  count of completed output handshakes.

Function
REQ-013 SHALL perform the mode 0 (PASS) permutation as dout = din.
REQ-014 SHALL perform the mode 1 (BITREV) permutation as dout[i] = din[WIDTH-1-i] for all i.
REQ-015 SHALL perform the mode 2 (BYTEREV) permutation by moving byte j to byte (WIDTH/8-1-j), with bit order inside each byte kept.
REQ-016 SHALL perform the mode 3 (BITREV_IN_BYTE) permutation by reversing bits within each byte, with byte positions kept.
REQ-017 SHALL implement a 2-stage pipeline: S1 registers din and mode, and S2 registers the permuted result and drives dout.
REQ-018 SHALL accept an input word on an edge where in_valid && in_ready; the word is loaded into S1.
REQ-019 SHALL deliver an output word on an edge where out_valid && out_ready.
REQ-020 SHALL define latency as follows: a word accepted at edge k has out_valid high after edge k+1, if not stalled.
REQ-021 SHALL advance S1 to S2 when S1 is valid and (S2 is empty or out_ready=1).
REQ-022 SHALL drive in_ready as (S1 empty) or (S1 advancing this cycle), combinationally from out_ready; this gives full throughput, one word per cycle.
REQ-023 SHALL hold dout, out_valid and S1 contents unchanged while out_valid=1 and out_ready=0; no word is lost or duplicated.
REQ-024 SHALL handle simultaneous accept and deliver in the same edge by moving both stages; word order is strictly preserved.
REQ-025 SHALL bind mode to its word; a change of mode between words SHALL NOT affect words already in the pipeline.
REQ-026 SHALL increment word_cnt by 1 on each output handshake and wrap from 2^CNT_W-1 to 0.
REQ-027 SHALL NOT drive in_ready from in_valid.
REQ-028 SHALL hold dout stable while out_valid=0; dout content is don't-care when out_valid=0.

Reset
REQ-029 SHALL, while rst_n=0 and independent of clk, force S1 and S2 to empty, out_valid=0, dout=0 and word_cnt=0.
REQ-030 SHALL hold in_ready=0 while rst_n=0, and drive it to 1 on the first cycle after release.
REQ-031 SHALL discard all in-flight words on a reset asserted mid-operation; no output handshake occurs for them after release.

Structure
REQ-032 SHALL place mode encodings MODE_PASS=0, MODE_BITREV=1, MODE_BYTEREV=2 and MODE_BITREV_IN_BYTE=3 in a shared package bit_reverse_pkg.
REQ-033 SHALL implement the permutation in one combinational sub-module, permute_core (WIDTH parameter, inputs data_in and mode, output data_out), instantiated between S1 and S2.
REQ-034 SHALL contain only handshake, pipeline registers and the counter in the top level, targeting 120-400 lines of RTL total.

Verification (WIDTH=16, CNT_W=4)
REQ-035 SHALL cover the mode sweep: din=16'h0001 with modes 0/1/2/3 -> dout 16'h0001 / 16'h8000 / 16'h0100 / 16'h0080; din=16'h1234 in mode 2 -> 16'h3412.
REQ-036 SHALL cover throughput: 8 back-to-back words with out_ready=1 -> in_ready stays 1, out_valid is continuous after edge k+1, and word_cnt=8.
REQ-037 SHALL cover backpressure: out_ready=0 for 4 cycles while 3 words are offered -> 2 accepted, in_ready=0, dout held; on release all 3 emerge in order.
REQ-038 SHALL cover mode change per word: alternate modes 1 and 2 every cycle on din=16'h00F1 -> outputs alternate 16'h8F00 and 16'hF100.
REQ-039 SHALL cover counter wrap: 17 handshakes -> word_cnt reads 15 after the 15th, 0 after the 16th and 1 after the 17th.
REQ-040 SHALL cover reset mid-stream: assert rst_n=0 with 2 words in flight and clk stopped -> out_valid=0 and word_cnt=0 immediately; after release no stale word appears.
